// File: rtl/byte_frame_pkg.sv
// Shared types and constants for the receive-side byte framer.
package byte_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CHK     = 3'd3,
      ST_DRAIN   = 3'd4
   } frame_state_t;

   typedef enum logic [1:0] {
      ERR_NONE = 2'b00,
      ERR_LEN  = 2'b01,
      ERR_CHK  = 2'b10,
      ERR_TMO  = 2'b11
   } err_code_t;

   localparam logic [7:0]  SOF_DEFAULT = 8'hA5;
   localparam logic [15:0] CNT_MAX     = 16'hFFFF;

   // Saturating increment used by the good/error frame counters.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      logic [15:0] r;
      if (v == CNT_MAX) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/frame_buf.sv
// Payload store: one write port, one combinational read port, no reset.
module frame_buf
   import byte_frame_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem_r [DEPTH];

   // Capture one payload byte per accepted write.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/byte_frame_rx.sv
// Receive framer: hunts SOF, parses length/payload/XOR checksum, stores the
// payload and forwards it store-and-forward with valid/ready and last marker.
module byte_frame_rx
   import byte_frame_pkg::*;
#(
   parameter logic [7:0] SOF     = SOF_DEFAULT,
   parameter int         MAX_LEN = 16,
   parameter int         TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_last,
   input  logic        out_ready,
   output logic        frame_done,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic [15:0] frame_cnt,
   output logic [15:0] err_cnt
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   frame_state_t  state_r;
   err_code_t     err_code_r;
   logic [7:0]    len_r;
   logic [7:0]    chk_r;
   logic [7:0]    wr_idx_r;
   logic [7:0]    rd_idx_r;
   logic [TW-1:0] idle_cnt_r;
   logic          in_ready_r;
   logic          out_valid_r;
   logic          out_last_r;
   logic          frame_done_r;
   logic          frame_err_r;
   logic [15:0]   frame_cnt_r;
   logic [15:0]   err_cnt_r;

   logic          in_hs_s;
   logic          out_hs_s;
   logic          in_frame_s;
   logic          tmo_s;
   logic          len_bad_s;
   logic          last_pay_s;
   logic          wr_en_s;
   logic          err_hit_s;
   logic          good_s;
   err_code_t     err_kind_s;
   logic [7:0]    rd_data_s;

   assign in_hs_s    = in_valid & in_ready_r;
   assign out_hs_s   = out_valid_r & out_ready;
   assign in_frame_s = (state_r == ST_LEN) | (state_r == ST_PAYLOAD) | (state_r == ST_CHK);
   assign tmo_s      = in_frame_s & ~in_hs_s & (idle_cnt_r == TW'(TIMEOUT - 1));
   assign len_bad_s  = (in_data == 8'd0) | (in_data > 8'(MAX_LEN));
   assign last_pay_s = (wr_idx_r == (len_r - 8'd1));
   assign wr_en_s    = (state_r == ST_PAYLOAD) & in_hs_s;

   // Classify this cycle: abort reason (timeout wins) or checksum match.
   always_comb begin
      err_hit_s  = 1'b0;
      err_kind_s = ERR_NONE;
      good_s     = 1'b0;
      if (tmo_s) begin
         err_hit_s  = 1'b1;
         err_kind_s = ERR_TMO;
      end else if (in_hs_s && (state_r == ST_LEN) && len_bad_s) begin
         err_hit_s  = 1'b1;
         err_kind_s = ERR_LEN;
      end else if (in_hs_s && (state_r == ST_CHK) && (in_data != chk_r)) begin
         err_hit_s  = 1'b1;
         err_kind_s = ERR_CHK;
      end else if (in_hs_s && (state_r == ST_CHK)) begin
         good_s = 1'b1;
      end else begin
         good_s = 1'b0;
      end
   end

   // Framing FSM with registered handshake, pulse and error-code outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         err_code_r   <= ERR_NONE;
         len_r        <= 8'd0;
         chk_r        <= 8'd0;
         wr_idx_r     <= 8'd0;
         rd_idx_r     <= 8'd0;
         idle_cnt_r   <= '0;
         in_ready_r   <= 1'b1;
         out_valid_r  <= 1'b0;
         out_last_r   <= 1'b0;
         frame_done_r <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         frame_done_r <= good_s;
         frame_err_r  <= err_hit_s;
         if (err_hit_s) begin
            state_r    <= ST_IDLE;
            err_code_r <= err_kind_s;
            wr_idx_r   <= 8'd0;
            chk_r      <= 8'd0;
            idle_cnt_r <= '0;
            in_ready_r <= 1'b1;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  idle_cnt_r <= '0;
                  if (in_hs_s && (in_data == SOF)) begin
                     state_r <= ST_LEN;
                  end
               end
               ST_LEN: begin
                  if (in_hs_s) begin
                     idle_cnt_r <= '0;
                     len_r      <= in_data;
                     chk_r      <= in_data;
                     wr_idx_r   <= 8'd0;
                     state_r    <= ST_PAYLOAD;
                  end else begin
                     idle_cnt_r <= idle_cnt_r + TW'(1);
                  end
               end
               ST_PAYLOAD: begin
                  if (in_hs_s) begin
                     idle_cnt_r <= '0;
                     chk_r      <= chk_r ^ in_data;
                     if (last_pay_s) begin
                        wr_idx_r <= 8'd0;
                        state_r  <= ST_CHK;
                     end else begin
                        wr_idx_r <= wr_idx_r + 8'd1;
                     end
                  end else begin
                     idle_cnt_r <= idle_cnt_r + TW'(1);
                  end
               end
               ST_CHK: begin
                  // A handshake here without an error is a checksum match.
                  if (in_hs_s) begin
                     idle_cnt_r  <= '0;
                     chk_r       <= 8'd0;
                     rd_idx_r    <= 8'd0;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                     out_last_r  <= (len_r == 8'd1);
                     state_r     <= ST_DRAIN;
                  end else begin
                     idle_cnt_r <= idle_cnt_r + TW'(1);
                  end
               end
               ST_DRAIN: begin
                  if (out_hs_s) begin
                     if (out_last_r) begin
                        rd_idx_r    <= 8'd0;
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                     end else begin
                        rd_idx_r   <= rd_idx_r + 8'd1;
                        out_last_r <= ((rd_idx_r + 8'd2) == len_r);
                     end
                  end
               end
               default: begin
                  state_r     <= ST_IDLE;
                  in_ready_r  <= 1'b1;
                  out_valid_r <= 1'b0;
                  out_last_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Saturating good-frame and aborted-frame counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_cnt_r <= 16'd0;
         err_cnt_r   <= 16'd0;
      end else begin
         if (good_s) begin
            frame_cnt_r <= sat_inc(frame_cnt_r);
         end
         if (err_hit_s) begin
            err_cnt_r <= sat_inc(err_cnt_r);
         end
      end
   end

   frame_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en_s),
      .wr_addr (wr_idx_r[AW-1:0]),
      .wr_data (in_data),
      .rd_addr (rd_idx_r[AW-1:0]),
      .rd_data (rd_data_s)
   );

   assign in_ready   = in_ready_r;
   assign out_valid  = out_valid_r;
   assign out_last   = out_last_r;
   assign out_data   = out_valid_r ? rd_data_s : 8'd0;
   assign frame_done = frame_done_r;
   assign frame_err  = frame_err_r;
   assign err_code   = err_code_r;
   assign frame_cnt  = frame_cnt_r;
   assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_byte_frame_rx.sv
// Self-checking bench for byte_frame_rx: directed scenarios plus randomized
// frame streams compared against a stream-parsing reference model.
module tb_byte_frame_rx;

   localparam int SOFV = 8'hA5;
   localparam int MAXL = 16;
   localparam int TMO  = 8;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_ready;
   logic        frame_done;
   logic        frame_err;
   logic [1:0]  err_code;
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // expected payload stream: bit 8 = last marker
   logic [8:0] exp_q[$];
   int exp_fcnt = 0;
   int exp_ecnt = 0;
   int exp_code = 0;
   int exp_done = 0;
   int exp_err  = 0;
   int mon_done = 0;
   int mon_err  = 0;
   int ready_mode = 0;

   byte_frame_rx #(
      .SOF     (8'hA5),
      .MAX_LEN (MAXL),
      .TIMEOUT (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .err_code   (err_code),
      .frame_cnt  (frame_cnt),
      .err_cnt    (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Pull the next byte of a frame, summing idle gaps; -1 means the gap
   // was long enough to abort the frame, -2 means the stream ran out.
   task automatic fetch(input int s[$], inout int i, output int b);
      int g = 0;
      while (i < s.size() && s[i] < 0) begin
         g += -s[i];
         i++;
      end
      if (g >= TMO) b = -1;
      else if (i >= s.size()) b = -2;
      else begin
         b = s[i];
         i++;
      end
   endtask

   task automatic note_err(input int c);
      exp_err++;
      if (exp_ecnt < 65535) exp_ecnt++;
      exp_code = c;
   endtask

   // Walk a stimulus list (>=0 byte, <0 idle gap) and record expectations.
   task automatic model_run(input int s[$]);
      int i = 0;
      int b, len, x;
      bit ok;
      int pl[$];
      while (i < s.size()) begin
         if (s[i] != SOFV) begin
            i++;
         end else begin
            i++;
            fetch(s, i, b);
            if (b == -2) break;
            if (b == -1) begin
               note_err(3);
            end else if (b == 0 || b > MAXL) begin
               note_err(1);
            end else begin
               len = b;
               x = len;
               ok = 1'b1;
               pl.delete();
               for (int k = 0; k < len; k++) begin
                  fetch(s, i, b);
                  if (b < 0) begin
                     ok = 1'b0;
                     break;
                  end
                  pl.push_back(b);
                  x = x ^ b;
               end
               if (ok) fetch(s, i, b);
               if (b == -2) break;
               if (b == -1) note_err(3);
               else if (b != x) note_err(2);
               else begin
                  exp_done++;
                  if (exp_fcnt < 65535) exp_fcnt++;
                  for (int k = 0; k < len; k++)
                     exp_q.push_back({(k == len - 1) ? 1'b1 : 1'b0, 8'(pl[k])});
               end
            end
         end
      end
   endtask

   // ---------------- drivers ----------------
   task automatic send_byte(input int b);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(b);
      while (!in_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) check_val("in_ready_wait", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int s[$]);
      foreach (s[k]) begin
         if (s[k] < 0) idle(-s[k]);
         else send_byte(s[k]);
      end
   endtask

   // Let the output drain, then compare counters, code and pulse totals.
   task automatic settle(input string tag);
      int t = 0;
      while (exp_q.size() > 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) check_val({tag, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      check_val({tag, "_frame_cnt"}, frame_cnt, exp_fcnt);
      check_val({tag, "_err_cnt"}, err_cnt, exp_ecnt);
      check_val({tag, "_err_code"}, err_code, exp_code);
      check_val({tag, "_done_pulses"}, mon_done, exp_done);
      check_val({tag, "_err_pulses"}, mon_err, exp_err);
   endtask

   task automatic run_stream(input string tag, input int s[$]);
      model_run(s);
      drive(s);
      settle(tag);
   endtask

   // ---------------- output ready pattern ----------------
   initial begin
      int cyc = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 3) == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      if (reset) begin
         if (frame_done) mon_done++;
         if (frame_err) mon_err++;
         if (out_valid) begin
            check_val("in_ready_in_drain", in_ready, 32'd0);
            if (exp_q.size() == 0) begin
               check_val("unexpected_out_valid", out_valid, 32'd0);
            end else begin
               check_val("out_data", out_data, exp_q[0][7:0]);
               check_val("out_last", out_last, exp_q[0][8]);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int s[$];
      int len, x, b, k;
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'd0;
      repeat (3) @(negedge clk);
      check_val("rst_in_ready", in_ready, 32'd1);
      check_val("rst_out_valid", out_valid, 32'd0);
      check_val("rst_out_data", out_data, 32'd0);
      check_val("rst_pulses", {frame_done, frame_err, out_last}, 32'd0);
      check_val("rst_err_code", err_code, 32'd0);
      check_val("rst_counts", {frame_cnt, err_cnt}, 32'd0);
      reset = 1'b1;

      // good frame; checksum covers the length byte, so it closes with 03
      s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      model_run(s);
      drive(s);
      check_val("good_done_latency", frame_done, 32'd1);
      check_val("good_valid_latency", out_valid, 32'd1);
      check_val("good_frame_cnt", frame_cnt, 32'd1);
      settle("good");

      // hunting plus bad checksum
      s = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
      model_run(s);
      drive(s);
      check_val("chk_err_pulse", frame_err, 32'd1);
      check_val("chk_err_code", err_code, 32'd2);
      check_val("chk_err_cnt", err_cnt, 32'd1);
      check_val("chk_in_ready", in_ready, 32'd1);
      settle("badchk");

      // length errors, then immediate good frame
      model_run('{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h7E, 8'h7F});
      drive('{8'hA5, 8'h00});
      check_val("len0_err_code", err_code, 32'd1);
      check_val("len0_err_pulse", frame_err, 32'd1);
      drive('{8'hA5, 8'h11});
      check_val("len17_err_code", err_code, 32'd1);
      check_val("len17_err_cnt", err_cnt, 32'd3);
      check_val("len17_in_ready", in_ready, 32'd1);
      drive('{8'hA5, 8'h01, 8'h7E, 8'h7F});
      settle("lenerr");

      // backpressure with a second frame queued right behind
      ready_mode = 1;
      run_stream("backpressure", '{8'hA5, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h26,
                                   8'hA5, 8'h01, 8'h7E, 8'h7F});
      ready_mode = 0;

      // timeout after exactly TMO idle cycles
      model_run('{8'hA5, 8'h02, 8'h55, -TMO, 8'hA5, 8'h01, 8'h7E, 8'h7F});
      drive('{8'hA5, 8'h02, 8'h55});
      idle(TMO - 1);
      check_val("tmo_not_yet", frame_err, 32'd0);
      idle(1);
      check_val("tmo_err_pulse", frame_err, 32'd1);
      check_val("tmo_err_code", err_code, 32'd3);
      drive('{8'hA5, 8'h01, 8'h7E, 8'h7F});
      settle("timeout");

      // reset mid-frame: nothing counted, no pulse, next frame still good
      drive('{8'hA5, 8'h02, 8'h55});
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_val("mid_rst_in_ready", in_ready, 32'd1);
      check_val("mid_rst_outs", {out_valid, out_last, frame_done, frame_err}, 32'd0);
      check_val("mid_rst_err_code", err_code, 32'd0);
      check_val("mid_rst_counts", {frame_cnt, err_cnt}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      exp_fcnt = 0;
      exp_ecnt = 0;
      exp_code = 0;
      run_stream("post_reset", '{8'hA5, 8'h01, 8'h7E, 8'h7F});

      // randomized mix of good, bad-checksum, bad-length and stalled frames
      ready_mode = 2;
      s.delete();
      for (int f = 0; f < 40; f++) begin
         repeat ($urandom_range(0, 2)) begin
            b = $urandom_range(0, 255);
            if (b == SOFV) b = 0;
            s.push_back(b);
         end
         k = $urandom_range(0, 5);
         s.push_back(SOFV);
         if (k == 4) begin
            s.push_back(($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(MAXL + 1, 255)));
         end else begin
            len = $urandom_range(1, MAXL);
            s.push_back(len);
            x = len;
            for (int p = 0; p < len; p++) begin
               if (k == 5 && p == int'($urandom_range(0, len - 1))) break;
               if ($urandom_range(0, 3) == 0) s.push_back(-int'($urandom_range(1, 3)));
               b = $urandom_range(0, 255);
               s.push_back(b);
               x = x ^ b;
            end
            if (k == 5) s.push_back(-int'($urandom_range(TMO, TMO + 3)));
            else if (k == 3) s.push_back(x ^ int'($urandom_range(1, 255)));
            else s.push_back(x);
         end
      end
      run_stream("random", s);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
